// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch port
// (IF, read only) and the load/store port (LS, read or write). One command is
// outstanding at a time: arbitrate in IDLE, drive the RAM for one cycle in
// ISSUE, count out the RAM read latency in WAIT, and pulse rvalid in RESP.
//
// Ports
//   clk, rst            clock, async active-low reset
//   if_req/if_addr      IF read request (held until if_gnt)
//   if_gnt/if_rvalid    IF issue pulse / read-data-valid pulse
//   if_rdata            IF read data, held until the next if_rvalid
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be   LS command (held until ls_gnt)
//   ls_gnt/ls_rvalid    LS issue pulse / read-data-valid pulse (reads only)
//   ls_rdata            LS read data, held until the next ls_rvalid
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata   RAM interface
//   busy                high whenever the FSM is not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; latch winner's command
// ISSUE | mem_en for one cycle, owner's gnt pulses
// WAIT  | lat_cnt counts down to 0, then mem_rdata is captured
// RESP  | owner's rvalid pulses for one cycle
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [3:0]    ls_be,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [1:0]    lat_cnt, lat_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic          take_if, take_ls, capture, ls_wins;

  logic          cmd_we;
  logic [3:0]    cmd_be;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    lat_nxt    = lat_cnt;
    starve_nxt = starve_cnt;
    take_if    = 1'b0;
    take_ls    = 1'b0;
    capture    = 1'b0;
    ls_wins    = 1'b0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: begin
        ls_wins = ls_req && !(if_req && starve_cnt == 4'(STARVE_MAX));
        take_ls = ls_wins;
        take_if = !ls_wins && if_req;
        // LS can only win against a pending IF while starve_cnt < STARVE_MAX,
        // so the increment below saturates by construction.
        if (take_ls && if_req) starve_nxt = starve_cnt + 4'd1;
        else                   starve_nxt = '0;
        if (take_ls || take_if) begin
          state_nxt = S_ISSUE;
          owner_nxt = take_ls ? OWN_LS : OWN_IF;
        end
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_we = cmd_we;
        if_gnt = (owner == OWN_IF);
        ls_gnt = (owner == OWN_LS);
        if (cmd_we) begin
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
        end else begin
          state_nxt = S_WAIT;
          lat_nxt   = 2'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (lat_cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          lat_nxt = lat_cnt - 2'd1;
        end
      end
      S_RESP: begin
        if_rvalid = (owner == OWN_IF);
        ls_rvalid = (owner == OWN_LS);
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Command latch doubles as the RAM address/data/be drivers, so those pins
  // hold their last value between accesses. IF write data is never used, so
  // an IF grant leaves cmd_wdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if (take_ls) begin
        cmd_we    <= ls_we;
        cmd_be    <= ls_be;
        cmd_addr  <= ls_addr;
        cmd_wdata <= ls_wdata;
      end else if (take_if) begin
        cmd_we   <= 1'b0;
        cmd_be   <= 4'hF;
        cmd_addr <= if_addr;
      end
      if (capture) begin
        if (owner == OWN_IF) if_rdata <= mem_rdata;
        if (owner == OWN_LS) ls_rdata <= mem_rdata;
      end
    end
  end

  assign mem_be    = cmd_be;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous data/instruction RAM between two requesters: the instruction-fetch unit (IF port) and the load/store path of the multi-cycle core (LS port). It arbitrates, latches the winning command, drives the RAM for one cycle, waits a programmable read latency and returns read data to the owner. The block sits between the IF/LS logic and the RAM macro. It is the only master on the RAM.

Parameters:
AW, 8, address width; matches the 8-bit PC.
DW, 32, data width.
RD_LAT, 1, RAM read latency in cycles (legal 1..4): cycles from mem_en to mem_rdata valid.
STARVE_MAX, 4, consecutive LS grants allowed while IF is pending before IF is forced (legal 1..15).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  AW  IF read address
if_gnt  out  1  one-cycle pulse: IF command issued to RAM
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  IF read data; holds until next if_rvalid
ls_req  in  1  LS request; held with command until ls_gnt
ls_we  in  1  1=write, 0=read
ls_addr  in  AW  LS address
ls_wdata  in  DW  write data
ls_be  in  4  byte enables for writes
ls_gnt  out  1  one-cycle pulse: LS command issued to RAM
ls_rvalid  out  1  one-cycle pulse (LS reads only): ls_rdata valid
ls_rdata  out  DW  LS read data; holds until next ls_rvalid
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_be  out  4  RAM byte enables
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after mem_en
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE; owner=none; lat_cnt=0; starve_cnt=0; all outputs 0, including if_rdata and ls_rdata. No pulse is emitted for an aborted transaction. The RAM write in flight at the reset edge must not be retried.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: evaluates requests each cycle.
  - If any request is present, latch owner and command (addr, we, wdata, be), then go to ISSUE.
  - If no request is present, stay in IDLE.
- Priority rule:
  - LS wins when both ports request, unless starve_cnt==STARVE_MAX; then IF wins.
  - A lone requester always wins.
  - IF requests are always reads: latched we=0, be=4'hF.
- starve_cnt update, at each IDLE decision:
  - LS granted while if_req=1: starve_cnt+1, saturating at STARVE_MAX.
  - IF granted, or if_req=0: starve_cnt=0.
- ISSUE (one cycle):
  - mem_en=1; mem_we/mem_be/mem_addr/mem_wdata driven from the latched command.
  - Owner's gnt=1.
  - Next state: WAIT for a read (lat_cnt loaded with RD_LAT-1); IDLE for a write.
  - Outside ISSUE, mem_en=0, mem_we=0, and the other mem_* outputs hold their last value.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (one cycle): owner's rvalid=1, then go to IDLE.
- Latency (request seen in IDLE at cycle t):
  - gnt and mem_en at t+1.
  - rvalid at t+2+RD_LAT.
  - Earliest next IDLE decision: t+2 after a write; t+3+RD_LAT after a read.
- Requester protocol:
  - A requester may change or drop req/command from the cycle after its gnt.
  - A request dropped before gnt is simply not seen.
  - Inputs are not re-sampled in ISSUE, WAIT or RESP.
- Exclusivity:
  - if_gnt and ls_gnt are never both 1.
  - if_rvalid and ls_rvalid are never both 1.
  - At most one transaction is outstanding.
- rdata registers change only in the cycle that loads them, i.e. the final WAIT cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0, busy=0; release rst -> no activity until a request arrives.
- IF read, RD_LAT=1: if_req=1, if_addr=8'h10 at cycle 0; RAM model returns 32'hE3A01005 -> if_gnt=1 and mem_en=1 with mem_addr=8'h10, mem_we=0, mem_be=4'hF at cycle 1; if_rvalid=1 with if_rdata=32'hE3A01005 at cycle 3; busy=0 at cycle 4.
- Simultaneous requests: if_req and ls_req (read, ls_addr=8'h20) both at cycle 0 -> ls_gnt at cycle 1, ls_rvalid at cycle 3; IF decision at cycle 4 -> if_gnt at cycle 5.
- Starvation, STARVE_MAX=4: if_req held high, ls_req re-raised immediately after each ls_gnt -> grants occur as LS, LS, LS, LS, IF; starve_cnt returns to 0 after the IF grant.
- LS write: ls_we=1, ls_addr=8'h44, ls_wdata=32'hDEADBEEF, ls_be=4'b0011 -> one cycle with mem_en=1, mem_we=1, mem_be=4'b0011 and matching addr/data; ls_gnt pulses; no ls_rvalid; busy falls the next cycle.
- RD_LAT=3, reset mid-WAIT: IF read issued, rst pulled low 2 cycles after if_gnt -> no if_rvalid, if_rdata=0, state IDLE; after reset release, a fresh if_req completes with if_rvalid 5 cycles after its request.
